// File: rtl/vec_exe_sequencer.sv
// EXE-stage vector sequencer: spreads one vector op over LANES ALU lanes,
// collects per-element results and overflow flags, and hands the finished
// vector to MEM with a valid/ready handshake.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no op in flight, ready to accept from ID
// RUN    | issuing one lane group per cycle, capturing results same edge
// DONE   | result vector presented to MEM, held until out_ready
module vec_exe_sequencer #(
  parameter int NUM_ELEM = 8,
  parameter int DATA_W   = 32,
  parameter int LANES    = 2,
  localparam int IDX_W   = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [3:0]                   in_vl,
  input  logic [5:0]                   in_funct,
  input  logic [4:0]                   in_write_addr,
  output logic                         alu_en,
  output logic [5:0]                   alu_funct,
  output logic [IDX_W-1:0]             alu_base_idx,
  output logic [LANES-1:0]             alu_lane_mask,
  input  logic [LANES*DATA_W-1:0]      alu_result,
  input  logic [LANES-1:0]             alu_overflow,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [4:0]                   out_write_addr,
  output logic [NUM_ELEM*DATA_W-1:0]   out_data,
  output logic [NUM_ELEM-1:0]          out_elem_mask,
  output logic [NUM_ELEM-1:0]          out_ovf_mask,
  output logic                         busy
);

  // Counter width covers base+LANES overshoot past the last element.
  localparam int CNT_W = ((IDX_W > 4) ? IDX_W : 4) + 2;
  localparam logic [CNT_W-1:0] NUM_ELEM_C = CNT_W'(NUM_ELEM);
  localparam logic [CNT_W-1:0] LANES_C    = CNT_W'(LANES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                       r_state;
  state_t                       w_state_nxt;
  logic [CNT_W-1:0]             r_base;
  logic [CNT_W-1:0]             r_vl;
  logic [5:0]                   r_funct;
  logic [4:0]                   r_waddr;
  logic [NUM_ELEM*DATA_W-1:0]   r_data;
  logic [NUM_ELEM-1:0]          r_elem_mask;
  logic [NUM_ELEM-1:0]          r_ovf_mask;

  logic [CNT_W-1:0]             w_vl_in;
  logic [CNT_W-1:0]             w_vl_eff;
  logic                         w_accept;
  logic                         w_last;
  logic [LANES-1:0]             w_lane_valid;

  assign w_vl_in  = CNT_W'(in_vl);
  assign w_vl_eff = (w_vl_in > NUM_ELEM_C) ? NUM_ELEM_C : w_vl_in;
  assign w_accept = in_valid & in_ready;
  assign w_last   = (r_base + LANES_C) >= r_vl;

  // Lane i carries a real element when base+i is still inside the vector.
  always_comb begin
    w_lane_valid = '0;
    for (int l = 0; l < LANES; l++) begin
      w_lane_valid[l] = (r_base + CNT_W'(l)) < r_vl;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and control outputs; flush overrides everything, including accept.
  always_comb begin
    w_state_nxt   = r_state;
    in_ready      = 1'b0;
    alu_en        = 1'b0;
    alu_funct     = '0;
    alu_base_idx  = '0;
    alu_lane_mask = '0;
    out_valid     = 1'b0;
    busy          = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        in_ready = ~flush;
      end
      S_RUN: begin
        alu_en        = 1'b1;
        alu_funct     = r_funct;
        alu_base_idx  = r_base[IDX_W-1:0];
        alu_lane_mask = w_lane_valid;
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready & ~flush;
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    if (in_valid && in_ready) begin
      w_state_nxt = (w_vl_eff == '0) ? S_DONE : S_RUN;
    end
    if (flush) w_state_nxt = S_IDLE;
  end

  // Op context and result buffer; lanes outside the vector never write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base      <= '0;
      r_vl        <= '0;
      r_funct     <= '0;
      r_waddr     <= '0;
      r_data      <= '0;
      r_elem_mask <= '0;
      r_ovf_mask  <= '0;
    end else if (flush) begin
      r_base      <= '0;
      r_vl        <= '0;
      r_funct     <= '0;
      r_waddr     <= '0;
      r_data      <= '0;
      r_elem_mask <= '0;
      r_ovf_mask  <= '0;
    end else if (w_accept) begin
      r_base      <= '0;
      r_vl        <= w_vl_eff;
      r_funct     <= in_funct;
      r_waddr     <= in_write_addr;
      r_data      <= '0;
      r_elem_mask <= '0;
      r_ovf_mask  <= '0;
    end else if (r_state == S_RUN) begin
      r_base <= r_base + LANES_C;
      for (int e = 0; e < NUM_ELEM; e++) begin
        for (int l = 0; l < LANES; l++) begin
          if (w_lane_valid[l] && ((r_base + CNT_W'(l)) == CNT_W'(e))) begin
            r_data[e*DATA_W +: DATA_W] <= alu_result[l*DATA_W +: DATA_W];
            r_ovf_mask[e]              <= alu_overflow[l];
            r_elem_mask[e]             <= 1'b1;
          end
        end
      end
    end
  end

  assign out_write_addr = r_waddr;
  assign out_data       = r_data;
  assign out_elem_mask  = r_elem_mask;
  assign out_ovf_mask   = r_ovf_mask;

endmodule

// File: tb/tb_vec_exe_sequencer.sv
// Directed bench for vec_exe_sequencer with a queue-based scoreboard.
module tb_vec_exe_sequencer;

  localparam int NE = 8;
  localparam int DW = 32;
  localparam int LN = 2;

  localparam logic [5:0] F_ADD = 6'h00;
  localparam logic [5:0] F_SUB = 6'h01;

  logic                 clk;
  logic                 rst_n;
  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic [3:0]           in_vl;
  logic [5:0]           in_funct;
  logic [4:0]           in_write_addr;
  logic                 alu_en;
  logic [5:0]           alu_funct;
  logic [2:0]           alu_base_idx;
  logic [LN-1:0]        alu_lane_mask;
  logic [LN*DW-1:0]     alu_result;
  logic [LN-1:0]        alu_overflow;
  logic                 out_valid;
  logic                 out_ready;
  logic [4:0]           out_write_addr;
  logic [NE*DW-1:0]     out_data;
  logic [NE-1:0]        out_elem_mask;
  logic [NE-1:0]        out_ovf_mask;
  logic                 busy;

  logic [2:0]           ovf_base;
  logic [LN-1:0]        ovf_lanes;

  int n_cmp = 0;
  int n_mis = 0;

  typedef struct {
    logic [2:0]  base;
    logic [1:0]  mask;
    logic [5:0]  funct;
  } beat_t;

  typedef struct {
    logic [255:0] data;
    logic [7:0]   emask;
    logic [7:0]   omask;
    logic [4:0]   waddr;
  } res_t;

  beat_t beat_q[$];
  res_t  res_q[$];

  vec_exe_sequencer #(.NUM_ELEM(NE), .DATA_W(DW), .LANES(LN)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_vl          (in_vl),
    .in_funct       (in_funct),
    .in_write_addr  (in_write_addr),
    .alu_en         (alu_en),
    .alu_funct      (alu_funct),
    .alu_base_idx   (alu_base_idx),
    .alu_lane_mask  (alu_lane_mask),
    .alu_result     (alu_result),
    .alu_overflow   (alu_overflow),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_write_addr (out_write_addr),
    .out_data       (out_data),
    .out_elem_mask  (out_elem_mask),
    .out_ovf_mask   (out_ovf_mask),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU element results: ADD of a=0x100*i+1, b=0x10*i gives 0x110*i+1; SUB gives 0xF0*i+1.
  function automatic logic [31:0] elem_val(input logic [5:0] f, input int idx);
    case (f)
      F_ADD:   return 32'h110 * 32'(idx) + 32'd1;
      F_SUB:   return 32'hF0 * 32'(idx) + 32'd1;
      default: return 32'hBAD0_0000 + 32'(idx);
    endcase
  endfunction

  // Lane model: results on every lane every cycle, overflow injected at one base.
  always_comb begin
    alu_result   = '0;
    alu_overflow = '0;
    for (int l = 0; l < LN; l++) begin
      alu_result[l*DW +: DW] = elem_val(alu_funct, int'(alu_base_idx) + l);
      alu_overflow[l]        = (alu_base_idx == ovf_base) ? ovf_lanes[l] : 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: checks every ALU beat and every MEM handshake against the queues.
  always @(negedge clk) begin
    beat_t b;
    res_t  r;
    if (rst_n) begin
      if (alu_en) begin
        if (beat_q.size() == 0) begin
          n_cmp++;
          n_mis++;
          $display("FAIL unexpected_alu_beat: got base %0d expected no beat", alu_base_idx);
        end else begin
          b = beat_q.pop_front();
          chk("alu_base_idx", 256'(alu_base_idx), 256'(b.base));
          chk("alu_lane_mask", 256'(alu_lane_mask), 256'(b.mask));
          chk("alu_funct", 256'(alu_funct), 256'(b.funct));
        end
      end
      if (out_valid && out_ready) begin
        if (res_q.size() == 0) begin
          n_cmp++;
          n_mis++;
          $display("FAIL unexpected_result: got addr %0d expected no result", out_write_addr);
        end else begin
          r = res_q.pop_front();
          chk("out_data", 256'(out_data), r.data);
          chk("out_elem_mask", 256'(out_elem_mask), 256'(r.emask));
          chk("out_ovf_mask", 256'(out_ovf_mask), 256'(r.omask));
          chk("out_write_addr", 256'(out_write_addr), 256'(r.waddr));
        end
      end
    end
  end

  function automatic logic [255:0] exp_vec(input logic [5:0] f, input int veff);
    logic [255:0] d;
    d = '0;
    for (int e = 0; e < veff; e++) d[e*32 +: 32] = elem_val(f, e);
    return d;
  endfunction

  // Present an op, wait for acceptance, and queue what it should produce.
  task automatic issue(input int vl, input logic [5:0] f, input logic [4:0] wa,
                       input logic [2:0] ob, input logic [1:0] ol,
                       input logic [7:0] em, input logic [7:0] om,
                       input int max_beats, input bit push_res);
    bit   ok;
    int   veff;
    int   nb;
    res_t r;
    in_vl         = 4'(vl);
    in_funct      = f;
    in_write_addr = wa;
    ovf_base      = ob;
    ovf_lanes     = ol;
    in_valid      = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      chk("accept_timeout", 256'(0), 256'(1));
      in_valid = 1'b0;
      return;
    end
    veff = (vl > NE) ? NE : vl;
    nb = 0;
    for (int b = 0; b < veff && nb < max_beats; b += LN) begin
      beat_q.push_back('{base: 3'(b), mask: (b + 1 < veff) ? 2'b11 : 2'b01, funct: f});
      nb++;
    end
    if (push_res) begin
      r.data  = exp_vec(f, veff);
      r.emask = em;
      r.omask = om;
      r.waddr = wa;
      res_q.push_back(r);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int exp_lat);
    int lat;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 40);
    chk("latency", 256'(lat), 256'(exp_lat));
  endtask

  typedef struct {
    int          vl;
    logic [5:0]  f;
    logic [4:0]  wa;
    logic [2:0]  ob;
    logic [1:0]  ol;
    logic [7:0]  em;
    logic [7:0]  om;
    int          lat;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #200000;
    n_mis++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    tbl[0] = '{vl: 8,  f: F_ADD, wa: 5'd3,  ob: 3'd0, ol: 2'b00, em: 8'hFF, om: 8'h00, lat: 5};
    tbl[1] = '{vl: 5,  f: F_SUB, wa: 5'd9,  ob: 3'd4, ol: 2'b11, em: 8'h1F, om: 8'h10, lat: 4};
    tbl[2] = '{vl: 0,  f: F_ADD, wa: 5'd1,  ob: 3'd0, ol: 2'b11, em: 8'h00, om: 8'h00, lat: 1};
    tbl[3] = '{vl: 12, f: F_ADD, wa: 5'd31, ob: 3'd0, ol: 2'b00, em: 8'hFF, om: 8'h00, lat: 5};
    tbl[4] = '{vl: 8,  f: F_ADD, wa: 5'd7,  ob: 3'd2, ol: 2'b10, em: 8'hFF, om: 8'h08, lat: 5};
    tbl[5] = '{vl: 1,  f: F_SUB, wa: 5'd4,  ob: 3'd0, ol: 2'b11, em: 8'h01, om: 8'h01, lat: 2};

    rst_n = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    in_vl = '0;
    in_funct = '0;
    in_write_addr = '0;
    out_ready = 1'b1;
    ovf_base = '0;
    ovf_lanes = '0;

    #12;
    chk("rst_in_ready", 256'(in_ready), 256'(1));
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_out_valid", 256'(out_valid), 256'(0));
    chk("rst_alu_en", 256'(alu_en), 256'(0));
    chk("rst_out_data", 256'(out_data), 256'(0));
    chk("rst_elem_mask", 256'(out_elem_mask), 256'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      issue(tbl[i].vl, tbl[i].f, tbl[i].wa, tbl[i].ob, tbl[i].ol, tbl[i].em, tbl[i].om, 99, 1'b1);
      wait_done(tbl[i].lat);
    end

    // MEM backpressure, then back-to-back accept out of DONE.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    issue(4, F_ADD, 5'd10, 3'd0, 2'b00, 8'h0F, 8'h00, 99, 1'b1);
    wait_done(3);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("hold_out_valid", 256'(out_valid), 256'(1));
      chk("hold_in_ready", 256'(in_ready), 256'(0));
      chk("hold_out_data", 256'(out_data), exp_vec(F_ADD, 4));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    issue(8, F_SUB, 5'd21, 3'd0, 2'b00, 8'hFF, 8'h00, 99, 1'b1);
    @(negedge clk);
    chk("b2b_alu_en", 256'(alu_en), 256'(1));
    chk("b2b_out_valid", 256'(out_valid), 256'(0));
    wait_done(4);

    // Flush in the second RUN cycle.
    @(posedge clk);
    #1;
    issue(8, F_ADD, 5'd2, 3'd0, 2'b00, 8'hFF, 8'h00, 2, 1'b0);
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", 256'(in_ready), 256'(0));
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", 256'(busy), 256'(0));
    chk("flush_out_data", 256'(out_data), 256'(0));
    chk("flush_elem_mask", 256'(out_elem_mask), 256'(0));
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("flush_no_valid", 256'(out_valid), 256'(0));
    end

    // Flush blocks acceptance from IDLE.
    @(posedge clk);
    #1;
    flush = 1'b1;
    in_valid = 1'b1;
    in_vl = 4'd3;
    @(negedge clk);
    chk("flush_idle_in_ready", 256'(in_ready), 256'(0));
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_idle_busy", 256'(busy), 256'(0));

    // Asynchronous reset in the middle of RUN.
    @(posedge clk);
    #1;
    issue(8, F_SUB, 5'd5, 3'd0, 2'b00, 8'hFF, 8'h00, 2, 1'b0);
    @(posedge clk);
    #1;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 256'(busy), 256'(0));
    chk("midrst_in_ready", 256'(in_ready), 256'(1));
    chk("midrst_alu_en", 256'(alu_en), 256'(0));
    chk("midrst_out_valid", 256'(out_valid), 256'(0));
    chk("midrst_out_data", 256'(out_data), 256'(0));
    chk("midrst_waddr", 256'(out_write_addr), 256'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    @(posedge clk);
    #1;
    issue(3, F_ADD, 5'd17, 3'd0, 2'b00, 8'h07, 8'h00, 99, 1'b1);
    wait_done(3);

    repeat (3) @(posedge clk);
    #1;
    chk("beat_q_empty", 256'(beat_q.size()), 256'(0));
    chk("res_q_empty", 256'(res_q.size()), 256'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
